// File: rtl/rx_data_merge.sv
// -----------------------------------------------------------------------------
// rx_data_merge
//   Receive-side merger that pairs with tx_data_split. A user request
//   (session, total bytes) is accepted, the TOE's per-chunk notifications for
//   that session are collected, and read-package requests of at most
//   MAX_READ_LEN bytes are issued. The chunked 512-bit RX stream is forwarded
//   as one message with a single last on its final beat. A completion status
//   follows the message.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   s_axis_rx_metadata_*      user request: data[47:16] total bytes, [15:0] session
//   s_axis_notification_*     TOE notification: data[31:16] chunk bytes, [15:0] session
//   m_axis_read_package_*     read request to TOE: data[31:16] bytes, [15:0] session
//   s_axis_rx_data_*          TOE chunk data (512b data, 64b keep, last per package)
//   m_axis_rx_data_*          merged message data to the user
//   m_axis_rx_status_*        completion: data[63:32] bytes, [31:16] 0, [15:0] session
//   drop_cnt                  saturating count of discarded foreign-session notifications
// -----------------------------------------------------------------------------
module rx_data_merge #(
  parameter int unsigned MAX_READ_LEN = 32'h8000,
  parameter int unsigned DROP_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  s_axis_rx_metadata_valid,
  output logic                  s_axis_rx_metadata_ready,
  input  logic [47:0]           s_axis_rx_metadata_data,

  input  logic                  s_axis_notification_valid,
  output logic                  s_axis_notification_ready,
  input  logic [31:0]           s_axis_notification_data,

  output logic                  m_axis_read_package_valid,
  input  logic                  m_axis_read_package_ready,
  output logic [31:0]           m_axis_read_package_data,

  input  logic                  s_axis_rx_data_valid,
  output logic                  s_axis_rx_data_ready,
  input  logic [511:0]          s_axis_rx_data_data,
  input  logic [63:0]           s_axis_rx_data_keep,
  input  logic                  s_axis_rx_data_last,

  output logic                  m_axis_rx_data_valid,
  input  logic                  m_axis_rx_data_ready,
  output logic [511:0]          m_axis_rx_data_data,
  output logic [63:0]           m_axis_rx_data_keep,
  output logic                  m_axis_rx_data_last,

  output logic                  m_axis_rx_status_valid,
  input  logic                  m_axis_rx_status_ready,
  output logic [63:0]           m_axis_rx_status_data,

  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_NOTIF,
    ISSUE,
    STREAM,
    STATUS
  } state_t;

  localparam logic [31:0]           MAX_LEN  = 32'(MAX_READ_LEN);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = DROP_CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  state_t      state, state_nxt;
  logic [15:0] sess;
  logic [31:0] total;
  logic [31:0] remaining;
  logic [15:0] notif_left;
  logic [15:0] rd_len;

  logic        meta_hs, notif_hs, rd_hs, last_hs, status_hs;
  logic [15:0] notif_len, notif_sess;
  logic [31:0] meta_total;

  // Smallest of three byte counts, compared at full 32-bit width. The result
  // always fits 16 bits because MAX_LEN does.
  function automatic logic [15:0] min3(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] c);
    logic [31:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m[15:0];
  endfunction

  assign notif_len  = s_axis_notification_data[31:16];
  assign notif_sess = s_axis_notification_data[15:0];
  assign meta_total = s_axis_rx_metadata_data[47:16];

  assign meta_hs   = s_axis_rx_metadata_valid  && s_axis_rx_metadata_ready;
  assign notif_hs  = s_axis_notification_valid && s_axis_notification_ready;
  assign rd_hs     = m_axis_read_package_valid && m_axis_read_package_ready;
  assign last_hs   = s_axis_rx_data_valid && s_axis_rx_data_ready && s_axis_rx_data_last;
  assign status_hs = m_axis_rx_status_valid && m_axis_rx_status_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first, so no path through
  // the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (meta_hs) state_nxt = (meta_total == 32'h0) ? STATUS : WAIT_NOTIF;
      WAIT_NOTIF: if (notif_hs && notif_sess == sess && notif_len != 16'h0) state_nxt = ISSUE;
      ISSUE:      if (rd_hs) state_nxt = STREAM;
      STREAM: begin
        if (last_hs) begin
          if (remaining == 32'h0)       state_nxt = STATUS;
          else if (notif_left != 16'h0) state_nxt = ISSUE;
          else                          state_nxt = WAIT_NOTIF;
        end
      end
      STATUS:     if (status_hs) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Request bookkeeping. rd_len is computed on the transition into ISSUE so the
  // read-package payload is a plain register and stays stable under backpressure.
  // NOTE: all datapath registers are reset; there is no memory array here, so
  // resetting everything costs nothing and keeps outputs defined after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sess       <= '0;
      total      <= '0;
      remaining  <= '0;
      notif_left <= '0;
      rd_len     <= '0;
      drop_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (meta_hs) begin
            sess      <= s_axis_rx_metadata_data[15:0];
            total     <= meta_total;
            remaining <= meta_total;
          end
        end
        WAIT_NOTIF: begin
          if (notif_hs) begin
            if (notif_sess == sess) begin
              if (notif_len != 16'h0) begin
                notif_left <= notif_len;
                rd_len     <= min3({16'h0, notif_len}, remaining, MAX_LEN);
              end
            end else if (drop_cnt != DROP_MAX) begin
              drop_cnt <= drop_cnt + DROP_ONE;
            end
          end
        end
        ISSUE: begin
          if (rd_hs) begin
            remaining <= remaining - {16'h0, rd_len};
            // Once the message is complete, chunk bytes beyond it stay in the TOE.
            notif_left <= (remaining == {16'h0, rd_len}) ? 16'h0 : notif_left - rd_len;
          end
        end
        STREAM: begin
          if (last_hs && remaining != 32'h0 && notif_left != 16'h0)
            rd_len <= min3({16'h0, notif_left}, remaining, MAX_LEN);
        end
        default: ;
      endcase
    end
  end

  // Output decode. Readies are qualified with rstn so nothing is accepted
  // while reset is held, even though the state register reads IDLE.
  always_comb begin
    s_axis_rx_metadata_ready  = 1'b0;
    s_axis_notification_ready = 1'b0;
    m_axis_read_package_valid = 1'b0;
    m_axis_read_package_data  = {rd_len, sess};
    s_axis_rx_data_ready      = 1'b0;
    m_axis_rx_data_valid      = 1'b0;
    m_axis_rx_data_data       = s_axis_rx_data_data;
    m_axis_rx_data_keep       = s_axis_rx_data_keep;
    m_axis_rx_data_last       = 1'b0;
    m_axis_rx_status_valid    = 1'b0;
    m_axis_rx_status_data     = {total, 16'h0, sess};
    unique case (state)
      IDLE:       s_axis_rx_metadata_ready  = rstn;
      WAIT_NOTIF: s_axis_notification_ready = rstn;
      ISSUE:      m_axis_read_package_valid = 1'b1;
      STREAM: begin
        // Zero-latency pass-through; last survives only on the message's final package.
        m_axis_rx_data_valid = s_axis_rx_data_valid;
        s_axis_rx_data_ready = m_axis_rx_data_ready && rstn;
        m_axis_rx_data_last  = s_axis_rx_data_last && (remaining == 32'h0);
      end
      STATUS:     m_axis_rx_status_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
